// File: rtl/block_raster_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : block_raster_writer_pkg
// Brief  : Shared geometry constants and drain-state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package block_raster_writer_pkg;

    localparam int DEF_IMG_W      = 256;
    localparam int DEF_IMG_H      = 256;
    localparam int DEF_PIX_W      = 8;
    localparam int BLK            = 8;
    localparam int BLKS_PER_STRIP = DEF_IMG_W / BLK;
    localparam int STRIPS         = DEF_IMG_H / BLK;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/block_raster_writer_strip_row_mem.sv
`default_nettype none
// ============================================================================
// Module : strip_row_mem
// Brief  : One strip-buffer row: one write port, one registered read port.
// Rev    : 1.0 - initial release
// ============================================================================
module strip_row_mem #(
    parameter int WORDS  = 32,
    parameter int WORD_W = 64,
    parameter int AW     = (WORDS > 1) ? $clog2(WORDS) : 1
)(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    // Pixel storage is deliberately not reset.
    logic [WORD_W-1:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/block_raster_writer.sv
`default_nettype none
// ============================================================================
// Module : block_raster_writer
// Brief  : Ping-pong strip buffers turning 8x8 blocks into raster pixel writes.
// Rev    : 1.0 - initial release
// ============================================================================
module block_raster_writer
    import block_raster_writer_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
)(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [BLK*BLK*PIX_W-1:0]       i_block_data,
    input  logic                           i_block_valid,
    output logic                           o_block_ready,
    output logic                           o_wr_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0] o_wr_addr,
    output logic [PIX_W-1:0]               o_wr_data,
    output logic                           o_frame_done
);

    localparam int c_addr_w    = $clog2(IMG_W*IMG_H);
    localparam int c_blks      = IMG_W / BLK;
    localparam int c_strips    = IMG_H / BLK;
    localparam int c_word_w    = BLK * PIX_W;
    localparam int c_kw        = (c_blks > 1) ? $clog2(c_blks) : 1;
    localparam int c_sw        = (c_strips > 1) ? $clog2(c_strips) : 1;
    localparam int c_cw        = $clog2(IMG_W);
    localparam int c_last_addr = IMG_W*IMG_H - 1;

    logic [1:0]          r_full;
    logic                r_fill_sel;
    logic                r_drain_sel;
    logic [c_kw-1:0]     r_blk;
    logic [c_sw-1:0]     r_strip;
    logic [2:0]          r_row;
    logic [c_cw-1:0]     r_col;
    drain_state_t        r_state;
    drain_state_t        w_state_nxt;

    logic                w_accept;
    logic                w_fill_last;
    logic                w_issue;
    logic                w_drain_last;
    logic [c_kw-1:0]     w_raddr;
    logic [c_addr_w-1:0] w_addr;

    logic                r_s1_valid;
    logic [c_addr_w-1:0] r_s1_addr;
    logic                r_s1_sel;
    logic [2:0]          r_s1_row;
    logic [2:0]          r_s1_byte;
    logic [c_word_w-1:0] w_rdata [2][BLK];
    logic [c_word_w-1:0] w_word;
    logic [PIX_W-1:0]    w_pix;

    assign o_block_ready = ~r_full[r_fill_sel];
    assign w_accept      = i_block_valid & o_block_ready;
    assign w_fill_last   = w_accept && (r_blk == c_kw'(c_blks-1));

    // Set and clear always target different buffers, so both take effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full     <= '0;
            r_fill_sel <= 1'b0;
            r_blk      <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_fill_last && (r_fill_sel == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_drain_last && (r_drain_sel == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
            if (w_accept) begin
                if (w_fill_last) begin
                    r_blk      <= '0;
                    r_fill_sel <= ~r_fill_sel;
                end else begin
                    r_blk <= r_blk + c_kw'(1);
                end
            end
        end
    end

    // Pixel 0 is issued on the IDLE->DRAIN transition to keep two-cycle latency.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_drain_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_drain_sel]) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_issue = 1'b1;
                if ((r_row == 3'(BLK-1)) && (r_col == c_cw'(IMG_W-1))) begin
                    w_drain_last = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_drain_sel <= 1'b0;
            r_strip     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                if (w_drain_last) begin
                    r_row       <= '0;
                    r_col       <= '0;
                    r_drain_sel <= ~r_drain_sel;
                    r_strip     <= (r_strip == c_sw'(c_strips-1)) ? '0 : r_strip + c_sw'(1);
                end else if (r_col == c_cw'(IMG_W-1)) begin
                    r_col <= '0;
                    r_row <= r_row + 3'd1;
                end else begin
                    r_col <= r_col + c_cw'(1);
                end
            end
        end
    end

    assign w_raddr = c_kw'(r_col >> 3);
    assign w_addr  = c_addr_w'((int'(r_strip) * BLK + int'(r_row)) * IMG_W + int'(r_col));

    generate
        for (genvar b = 0; b < 2; b++) begin : g_buf
            for (genvar r = 0; r < BLK; r++) begin : g_row
                strip_row_mem #(
                    .WORDS  (c_blks),
                    .WORD_W (c_word_w),
                    .AW     (c_kw)
                ) u_mem (
                    .i_clk   (i_clk),
                    .i_we    (w_accept && (r_fill_sel == 1'(b))),
                    .i_waddr (r_blk),
                    .i_wdata (i_block_data[r*c_word_w +: c_word_w]),
                    .i_raddr (w_raddr),
                    .o_rdata (w_rdata[b][r])
                );
            end
        end
    endgenerate

    assign w_word = w_rdata[r_s1_sel][r_s1_row];
    assign w_pix  = w_word[r_s1_byte*PIX_W +: PIX_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_sel     <= 1'b0;
            r_s1_row     <= '0;
            r_s1_byte    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_addr <= w_addr;
                r_s1_sel  <= r_drain_sel;
                r_s1_row  <= r_row;
                r_s1_byte <= r_col[2:0];
            end
            o_wr_en <= r_s1_valid;
            if (r_s1_valid) begin
                o_wr_addr <= r_s1_addr;
                o_wr_data <= w_pix;
            end
            o_frame_done <= o_wr_en && (o_wr_addr == c_addr_w'(c_last_addr));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_raster_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_block_raster_writer
// Brief  : Randomised self-checking bench with a strip/raster reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_block_raster_writer;

    localparam int IMG_W     = 64;
    localparam int IMG_H     = 24;
    localparam int PIX_W     = 8;
    localparam int BLKS      = IMG_W / 8;
    localparam int STRIPS    = IMG_H / 8;
    localparam int STRIP_PIX = 8 * IMG_W;
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int AW        = $clog2(FRAME_PIX);
    localparam int BW        = 64 * PIX_W;

    logic              clk;
    logic              rst_n;
    logic [BW-1:0]     block_data;
    logic              block_valid;
    logic              block_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;

    block_raster_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_block_data  (block_data),
        .i_block_valid (block_valid),
        .o_block_ready (block_ready),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int n_fd     = 0;
    int first_wr_cyc = -1;
    bit prev_wr_en = 1'b0;
    bit exp_fd     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: image strip assembled from blocks, emitted in raster order.
    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [PIX_W-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    logic [PIX_W-1:0] m_buf [8][IMG_W];
    int               m_k     = 0;
    int               m_strip = 0;

    task automatic model_accept(input logic [BW-1:0] d);
        wr_t w;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_buf[r][m_k*8 + c] = d[(r*8 + c)*PIX_W +: PIX_W];
        m_k++;
        if (m_k == BLKS) begin
            m_k = 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < IMG_W; c++) begin
                    w.addr = AW'((m_strip*8 + r)*IMG_W + c);
                    w.data = m_buf[r][c];
                    exp_q.push_back(w);
                end
            m_strip = (m_strip + 1) % STRIPS;
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst_n) begin
            exp_fd     = 1'b0;
            prev_wr_en = 1'b0;
        end else begin
            if (frame_done || exp_fd) begin
                n_checks++;
                if (frame_done !== exp_fd)
                    $display("FAIL frame_done: got %b required %b at cycle %0d", frame_done, exp_fd, cyc);
                else
                    n_pass++;
            end
            if (frame_done) n_fd++;
            exp_fd = 1'b0;
            if (wr_en) begin
                if (!prev_wr_en) first_wr_cyc = cyc;
                n_wr++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_write: got addr %0d data %0h, required no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data)
                        $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                                 wr_addr, wr_data, e.addr, e.data);
                    else
                        n_pass++;
                    exp_fd = (int'(e.addr) == FRAME_PIX - 1);
                end
            end
            prev_wr_en = wr_en;
        end
    end

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] v;
        for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BW-1:0] pattern_block(input int k);
        logic [BW-1:0] v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                v[(r*8 + c)*PIX_W +: PIX_W] = PIX_W'(8*k + c);
        return v;
    endfunction

    // Garbage is driven whenever the block must be ignored (valid low or stalled).
    task automatic send_block(input logic [BW-1:0] d, input int max_gap, output int acc_cyc);
        int guard;
        if (max_gap > 0) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                block_data = rand_block();
            end
        end
        @(negedge clk);
        block_valid = 1'b1;
        block_data  = d;
        guard = 0;
        while (block_ready !== 1'b1 && guard < 5000) begin
            block_data = rand_block();
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_checks++;
            $display("FAIL ready_timeout: got ready %b for 5000 cycles, required 1", block_ready);
            block_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        block_data = d;
        model_accept(d);
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        block_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        block_valid = 1'b0;
        exp_q.delete();
        m_k     = 0;
        m_strip = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) $display("FAIL %s: got %0d required %0d", name, got, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_int("reset_ready", int'(block_ready), 1);
        check_int("reset_wr_en", int'(wr_en), 0);
        check_int("reset_wr_addr", int'(wr_addr), 0);
        check_int("reset_wr_data", int'(wr_data), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
    endtask

    task automatic test_strip(input string name, input int max_gap);
        int acc = 0;
        int wr0;
        do_reset();
        wr0 = n_wr;
        for (int k = 0; k < BLKS; k++) send_block(pattern_block(k), max_gap, acc);
        wait_drain(name);
        check_int({name, "_latency"}, first_wr_cyc, acc + 2);
        check_int({name, "_count"}, n_wr - wr0, STRIP_PIX);
    endtask

    task automatic test_back_to_back();
        int acc[3*BLKS];
        int wr0;
        int fd0;
        do_reset();
        wr0 = n_wr;
        fd0 = n_fd;
        for (int i = 0; i < 3*BLKS; i++) send_block(rand_block(), 0, acc[i]);
        check_int("b2b_no_stall", acc[BLKS] - acc[BLKS-1], 1);
        check_int("b2b_stall", acc[2*BLKS] - acc[2*BLKS-1], STRIP_PIX + 1 - BLKS);
        wait_drain("b2b");
        check_int("b2b_count", n_wr - wr0, 3*STRIP_PIX);
        check_int("b2b_frame_done", n_fd - fd0, 1);
    endtask

    task automatic test_frame();
        int acc;
        int wr0;
        int fd0;
        do_reset();
        wr0 = n_wr;
        fd0 = n_fd;
        for (int i = 0; i < (STRIPS+1)*BLKS; i++) send_block(rand_block(), 2, acc);
        wait_drain("frame");
        check_int("frame_count", n_wr - wr0, FRAME_PIX + STRIP_PIX);
        check_int("frame_done_pulses", n_fd - fd0, 1);
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        int wr0;
        int guard = 0;
        do_reset();
        wr0 = n_wr;
        for (int i = 0; i < 2*BLKS; i++) send_block(rand_block(), 0, acc);
        while (n_wr - wr0 < 300 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_int("mid_reached", int'(n_wr - wr0 >= 300), 1);
        check_int("mid_ready_before", int'(block_ready), 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_k     = 0;
        m_strip = 0;
        #1;
        check_int("mid_ready", int'(block_ready), 1);
        check_int("mid_wr_en", int'(wr_en), 0);
        check_int("mid_frame_done", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr0 = n_wr;
        for (int i = 0; i < BLKS; i++) send_block(rand_block(), 1, acc);
        wait_drain("mid");
        check_int("mid_count", n_wr - wr0, STRIP_PIX);
    endtask

    initial begin
        rst_n       = 1'b0;
        block_valid = 1'b0;
        block_data  = '0;
        test_reset();
        test_strip("strip", 0);
        test_strip("gaps", 5);
        test_back_to_back();
        test_frame();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_raster_writer.md
BLOCK_RASTER_WRITER -- requirements
Module: block_raster_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 256, image width in pixels (multiple of 8).
REQ-002 SHALL have parameter IMG_H, default 256, image height in pixels (multiple of 8).
REQ-003 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_block_data  input  64*PIX_W (512)  8x8 pixel block; pixel(r,c) at bits [(r*8+c)*PIX_W +: PIX_W].
REQ-007 SHALL have port i_block_valid  input  1  i_block_data valid.
REQ-008 SHALL have port o_block_ready  output  1  block accepted when valid and ready are both high.
REQ-009 SHALL have port o_wr_en  output  1  output memory write strobe.
REQ-010 SHALL have port o_wr_addr  output  log2(IMG_W*IMG_H) (16)  raster pixel address.
REQ-011 SHALL have port o_wr_data  output  PIX_W  pixel value.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 SHALL hold two strip buffers (ping-pong), each 8 rows x IMG_W pixels, plus one full flag per buffer.
REQ-014 SHALL drive o_block_ready high iff the current fill buffer's full flag is clear.
REQ-015 SHALL, on accept, write block number k (0..IMG_W/8-1) of the current strip into columns 8k..8k+7, all 8 rows, in one cycle.
REQ-016 SHALL, on accepting block IMG_W/8-1, set that buffer's full flag, reset k to 0, and toggle the fill buffer.
REQ-017 SHALL run a drain FSM with states IDLE and DRAIN: IDLE->DRAIN when the drain buffer's full flag is set; DRAIN->IDLE after the 8*IMG_W-th pixel is issued, clearing that buffer's full flag and toggling the drain buffer.
REQ-018 SHALL issue one pixel per cycle in DRAIN, order row 0 col 0..IMG_W-1, then row 1, ... row 7, with no gaps.
REQ-019 SHALL set o_wr_addr = (strip*8 + r)*IMG_W + c and o_wr_data = pixel(r,c), where strip counts 0..IMG_H/8-1.
REQ-020 SHALL register o_wr_en/o_wr_addr/o_wr_data; first o_wr_en SHALL occur exactly 2 cycles after the accept edge of the strip's last block (drain buffer previously empty).
REQ-021 SHALL wrap strip to 0 after strip IMG_H/8-1 and pulse o_frame_done the cycle after the write of address IMG_W*IMG_H-1.
REQ-022 SHALL allow filling one buffer while draining the other; a clear of one flag and a set of the other flag in the same cycle SHALL both take effect.
REQ-023 SHALL ignore i_block_data when i_block_valid is low or o_block_ready is low; idle gaps SHALL not alter output order.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously clear: full flags, k, strip, fill/drain selectors, FSM to IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_frame_done=0; o_block_ready=1 after reset.
REQ-025 SHALL NOT clear strip buffer contents on reset; a partial strip in progress is discarded.

Structure
REQ-026 SHALL place IMG_W, IMG_H, PIX_W defaults, BLK=8, BLKS_PER_STRIP, STRIPS and the drain-state encoding in a shared package.
REQ-027 SHALL use one sub-module strip_row_mem: IMG_W/8 x 8*PIX_W words, one write port, one registered read port; 16 instances (2 buffers x 8 rows), byte select by c[2:0] after read.

Verification
REQ-028 Reset asserted mid-stream -> o_block_ready=1, o_wr_en=0, o_frame_done=0 immediately, without a clock edge.
REQ-029 32 blocks of strip 0 with pixel(r,c)=(8k+c)[7:0] -> 2048 writes, addr 0..2047 consecutive, data=addr[7:0], first o_wr_en 2 cycles after the last accept.
REQ-030 96 blocks (3 strips) back-to-back with valid held high -> ready low after block 64 until strip 0 drain completes; all 6144 writes correct, none lost or duplicated.
REQ-031 Full frame (1024 blocks) -> 65536 writes, single o_frame_done pulse after addr 65535; next strip starts at addr 0.
REQ-032 Reset pulse during drain at pixel 1000, then a new strip -> writes restart at addr 0 with the new data only.
REQ-033 Same stimulus as REQ-029 with random valid gaps -> output sequence identical to REQ-029.
